i2c_txn_arbiter: RTL and testbench

Round-robin transaction arbiter that shares the single-byte I2C master controller between up to NREQ on-chip requesters. It accepts one-byte read or write requests, latches the winner's address, direction and data, and drives the controller's start, addr, write and data_in inputs. It waits for the controller's done and returns the read byte or a completion pulse to the granted requester. It sits between the system-side request logic and the I2C controller, in the 100 MHz domain.

---
 rtl/i2c_txn_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter
//   Round-robin arbiter that shares one single-byte I2C master controller
//   between NREQ requesters. The winner's direction, address and write byte
//   are latched on the IDLE->ISSUE edge and held steady until the arbiter
//   returns to IDLE. The read byte (or 8'h00 for writes) comes back with a
//   one-cycle rsp_valid pulse to the granted requester.
//
//   Optional feature: define I2C_ARB_TIMEOUT_EN to build a watchdog that
//   ends a transaction after TIMEOUT_CYC cycles in ISSUE/WAIT with rsp_err=1.
//   Without the macro there is no counter and rsp_err is always 0.
//
//   Handshake: requester i holds req[i] (and its fields) high until it sees
//   rsp_valid[i]. The controller accepts a start when m_busy is seen high
//   while m_start is asserted. Completion is a fresh 0->1 edge of m_done
//   seen in WAIT; a level that is already high on entry is ignored.
//
// Ports
//   clk_100m, rst                     clock, synchronous active-high reset
//   req/req_write/req_addr/req_wdata  per-requester request fields
//   gnt, rsp_valid, rsp_rdata, rsp_err  requester-side grant and response
//   m_start/m_write/m_addr/m_data_in  controller command
//   m_busy, m_done, m_data_out        controller status and read data
//   dbg_state                         current FSM state (IDLE=0 .. RESP=3)
module i2c_txn_arbiter #(
   parameter int NREQ        = 4,
   parameter int TIMEOUT_CYC = 20000
) (
   input  logic              clk_100m,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   req_write,
   input  logic [7*NREQ-1:0] req_addr,
   input  logic [8*NREQ-1:0] req_wdata,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [7:0]        rsp_rdata,
   output logic              rsp_err,
   output logic              m_start,
   output logic              m_write,
   output logic [6:0]        m_addr,
   output logic [7:0]        m_data_in,
   input  logic              m_busy,
   input  logic              m_done,
   input  logic [7:0]        m_data_out,
   output logic [1:0]        dbg_state
);

   localparam int IW = $clog2(NREQ);

   if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 2) begin : g_param_check
      $error("i2c_txn_arbiter: parameter out of range");
   end

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   gnt_idx;
   logic [IW-1:0]   sel_idx;
   logic            sel_found;
   logic [NREQ-1:0] gnt_q;
   logic            done_q;
   logic            done_rise;
   logic            timeout_hit;
   logic [7:0]      rdata_q;
   logic            err_q;
   logic            m_write_q;
   logic [6:0]      m_addr_q;
   logic [7:0]      m_data_q;

   assign done_rise = m_done & ~done_q;

`ifdef I2C_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC);
   logic [CW-1:0] to_cnt;

   // Held at zero in IDLE so it starts from 0 on entry to ISSUE.
   always_ff @(posedge clk_100m) begin
      if (rst)                               to_cnt <= '0;
      else if (state == IDLE)                to_cnt <= '0;
      else if (state == ISSUE || state == WAIT) to_cnt <= to_cnt + 1'b1;
   end

   assign timeout_hit = (state == ISSUE || state == WAIT) &&
                        (to_cnt == CW'(TIMEOUT_CYC - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   // Round-robin pick: scan downward so the lowest offset from rr_ptr
   // is the last (winning) assignment.
   always_comb begin
      int idx;
      idx       = 0;
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (req[IW'(idx)]) begin
            sel_found = 1'b1;
            sel_idx   = IW'(idx);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (sel_found) state_nxt = ISSUE;
         ISSUE:   if (timeout_hit) state_nxt = RESP;
                  else if (m_busy) state_nxt = WAIT;
         WAIT:    if (done_rise || timeout_hit) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_100m) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         gnt_idx   <= '0;
         gnt_q     <= '0;
         done_q    <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         m_write_q <= 1'b0;
         m_addr_q  <= '0;
         m_data_q  <= '0;
      end else begin
         state  <= state_nxt;
         done_q <= m_done;
         unique case (state)
            IDLE: if (sel_found) begin
               gnt_idx   <= sel_idx;
               gnt_q     <= {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
               m_write_q <= req_write[sel_idx];
               m_addr_q  <= req_addr[int'(sel_idx)*7 +: 7];
               m_data_q  <= req_wdata[int'(sel_idx)*8 +: 8];
               rdata_q   <= '0;
               err_q     <= 1'b0;
            end
            ISSUE: if (timeout_hit) begin
               rdata_q <= '0;
               err_q   <= 1'b1;
            end
            // Completion takes priority over a watchdog expiring in the same cycle.
            WAIT: if (done_rise) begin
               rdata_q <= m_write_q ? 8'h00 : m_data_out;
               err_q   <= 1'b0;
            end else if (timeout_hit) begin
               rdata_q <= '0;
               err_q   <= 1'b1;
            end
            RESP: begin
               rr_ptr    <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
               gnt_q     <= '0;
               m_write_q <= 1'b0;
               m_addr_q  <= '0;
               m_data_q  <= '0;
               rdata_q   <= '0;
               err_q     <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign rsp_valid = (state == RESP) ? gnt_q : '0;
   assign rsp_rdata = (state == RESP) ? rdata_q : 8'h00;
   assign rsp_err   = (state == RESP) ? err_q : 1'b0;
   assign m_start   = (state == ISSUE);
   assign m_write   = m_write_q;
   assign m_addr    = m_addr_q;
   assign m_data_in = m_data_q;
   assign dbg_state = state;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
module tb_i2c_txn_arbiter;

   localparam int NREQ = 4;

   logic              clk_100m = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   req_write;
   logic [7*NREQ-1:0] req_addr;
   logic [8*NREQ-1:0] req_wdata;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   rsp_valid;
   logic [7:0]        rsp_rdata;
   logic              rsp_err;
   logic              m_start;
   logic              m_write;
   logic [6:0]        m_addr;
   logic [7:0]        m_data_in;
   logic              m_busy;
   logic              m_done;
   logic [7:0]        m_data_out;
   logic [1:0]        dbg_state;

   int n_vec = 0;
   int n_err = 0;

   i2c_txn_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(16)) dut (
      .clk_100m(clk_100m), .rst(rst),
      .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .m_start(m_start), .m_write(m_write), .m_addr(m_addr), .m_data_in(m_data_in),
      .m_busy(m_busy), .m_done(m_done), .m_data_out(m_data_out),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk_100m = ~clk_100m;

   initial begin
      #2ms;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk_100m);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      m_busy = 1'b0; m_done = 1'b0; m_data_out = '0;
      step(); step();
      rst = 1'b0;
   endtask

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_gnt"}, 32'(gnt), 0);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
      chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 0);
      chk({tag, "_rsp_err"}, 32'(rsp_err), 0);
      chk({tag, "_m_start"}, 32'(m_start), 0);
      chk({tag, "_m_write"}, 32'(m_write), 0);
      chk({tag, "_m_addr"}, 32'(m_addr), 0);
      chk({tag, "_m_data_in"}, 32'(m_data_in), 0);
   endtask

   // ---------------- driver ----------------
   // Starts in IDLE with requester inputs already applied; ends in IDLE.
   task automatic do_txn(input logic [3:0] eg, input logic ew, input logic [6:0] ea,
                         input logic [7:0] ed, input logic [7:0] er, input logic [7:0] dout,
                         input int busy_dly, input int done_dly, input bit scramble,
                         input bit keep_done);
      step();
      chk("grant", 32'(gnt), 32'(eg));
      chk("start_rise", 32'(m_start), 1);
      chk("m_write", 32'(m_write), 32'(ew));
      chk("m_addr", 32'(m_addr), 32'(ea));
      chk("m_data_in", 32'(m_data_in), 32'(ed));
      if (scramble) begin
         req = 4'($urandom); req_write = 4'($urandom);
         req_addr = 28'($urandom); req_wdata = $urandom;
      end
      for (int i = 0; i < busy_dly; i++) begin
         step();
         chk("start_hold", 32'(m_start), 1);
      end
      m_busy = 1'b1;
      step();
      m_busy = 1'b0;
      chk("start_fall", 32'(m_start), 0);
      chk("gnt_hold", 32'(gnt), 32'(eg));
      if (m_done) begin
         for (int i = 0; i < 2; i++) begin
            step();
            chk("stale_done_no_rsp", 32'(rsp_valid), 0);
         end
         m_done = 1'b0;
         step();
         chk("stale_done_low_no_rsp", 32'(rsp_valid), 0);
      end
      for (int i = 0; i < done_dly; i++) begin
         step();
         chk("wait_no_rsp", 32'(rsp_valid), 0);
         chk("addr_hold", 32'(m_addr), 32'(ea));
         chk("wdata_hold", 32'(m_data_in), 32'(ed));
      end
      m_data_out = dout;
      m_done = 1'b1;
      step();
      chk("rsp_valid", 32'(rsp_valid), 32'(eg));
      chk("rsp_rdata", 32'(rsp_rdata), 32'(er));
      chk("rsp_err", 32'(rsp_err), 0);
      if (!keep_done) m_done = 1'b0;
      step();
      chk("idle_gnt", 32'(gnt), 0);
      chk("idle_rsp_valid", 32'(rsp_valid), 0);
      chk("idle_m_start", 32'(m_start), 0);
   endtask

   task automatic apply_fields(input logic [3:0] rq, input logic [3:0] wr,
                               input logic [6:0] abase, input logic [7:0] dbase);
      req = rq; req_write = wr;
      for (int i = 0; i < NREQ; i++) begin
         req_addr[i*7 +: 7]  = abase + 7'(i);
         req_wdata[i*8 +: 8] = dbase + 8'(i);
      end
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [3:0] rq;
      logic [3:0] wr;
      logic [6:0] abase;
      logic [7:0] dbase;
      logic [7:0] dout;
      bit         keep;
      logic [3:0] eg;
      logic       ew;
      logic [6:0] ea;
      logic [7:0] ed;
      logic [7:0] er;
   } vec_t;

   vec_t tbl[6];

   initial begin
      logic [3:0]  rq;
      logic [3:0]  wr_s;
      logic [27:0] ad_s;
      logic [31:0] wd_s;
      logic [7:0]  dout;
      int          rr_m;
      int          w;
      int          cyc;

      // rr_ptr walk: 0 -> 1 -> 3 -> 0 -> 2 -> 1 -> 0
      tbl[0] = '{4'b0001, 4'b0001, 7'd14,  8'hA5, 8'h00, 1'b0, 4'b0001, 1'b1, 7'd14,  8'hA5, 8'h00};
      tbl[1] = '{4'b0100, 4'b0000, 7'd32,  8'h10, 8'h3C, 1'b0, 4'b0100, 1'b0, 7'd34,  8'h12, 8'h3C};
      tbl[2] = '{4'b1111, 4'b1010, 7'd50,  8'h20, 8'h99, 1'b1, 4'b1000, 1'b1, 7'd53,  8'h23, 8'h00};
      tbl[3] = '{4'b0110, 4'b0000, 7'd100, 8'hF0, 8'h81, 1'b0, 4'b0010, 1'b0, 7'd101, 8'hF1, 8'h81};
      tbl[4] = '{4'b0011, 4'b0001, 7'd120, 8'h77, 8'hEE, 1'b0, 4'b0001, 1'b1, 7'd120, 8'h77, 8'h00};
      tbl[5] = '{4'b1001, 4'b0000, 7'd7,   8'h00, 8'h5A, 1'b0, 4'b1000, 1'b0, 7'd10,  8'h03, 8'h5A};

      do_reset();
      chk_all_zero("reset");
      step();
      chk_all_zero("idle_no_req");

      // Table: entry 2 leaves m_done high so entry 3 sees a stale level.
      for (int i = 0; i < 6; i++) begin
         apply_fields(tbl[i].rq, tbl[i].wr, tbl[i].abase, tbl[i].dbase);
         do_txn(tbl[i].eg, tbl[i].ew, tbl[i].ea, tbl[i].ed, tbl[i].er, tbl[i].dout,
                1, 2, 1'b0, tbl[i].keep);
      end

      // Contention from reset: all four requesting, order 0,1,2,3,0.
      do_reset();
      apply_fields(4'b1111, 4'b1111, 7'd0, 8'h40);
      for (int i = 0; i < 5; i++) begin
         w = i % 4;
         do_txn(4'(1 << w), 1'b1, 7'(w), 8'(8'h40 + w), 8'h00, 8'hFF, 0, 0, 1'b0, 1'b0);
      end

      // Reset mid-WAIT aborts without a response; arbitration restarts at 0.
      apply_fields(4'b1111, 4'b0000, 7'd60, 8'h00);
      step();
      chk("pre_abort_gnt", 32'(gnt), 32'(4'b0010));
      m_busy = 1'b1; step(); m_busy = 1'b0;
      rst = 1'b1;
      step();
      chk_all_zero("reset_mid_wait");
      rst = 1'b0;
      do_txn(4'b0001, 1'b0, 7'd60, 8'h00, 8'hC3, 8'hC3, 0, 1, 1'b0, 1'b0);

      // Randomized traffic against a round-robin reference model.
      do_reset();
      rr_m = 0;
      for (int it = 0; it < 60; it++) begin
         rq   = 4'($urandom_range(0, 15));
         wr_s = 4'($urandom); ad_s = 28'($urandom); wd_s = $urandom;
         dout = 8'($urandom);
         req = rq; req_write = wr_s; req_addr = ad_s; req_wdata = wd_s;
         if (rq == 4'b0000) begin
            step();
            chk("rand_idle_gnt", 32'(gnt), 0);
            chk("rand_idle_start", 32'(m_start), 0);
            continue;
         end
         w = -1;
         for (int k = 0; k < NREQ; k++)
            if (w < 0 && rq[(rr_m + k) % NREQ]) w = (rr_m + k) % NREQ;
         do_txn(4'(1 << w), wr_s[w], ad_s[w*7 +: 7], wd_s[w*8 +: 8],
                wr_s[w] ? 8'h00 : dout, dout,
                $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, 1'($urandom_range(0, 1)));
         rr_m = (w + 1) % NREQ;
      end

`ifdef I2C_ARB_TIMEOUT_EN
      // Controller never accepts: watchdog ends the transaction with rsp_err.
      do_reset();
      apply_fields(4'b0001, 4'b0000, 7'd5, 8'h00);
      step();
      chk("to_grant", 32'(gnt), 1);
      cyc = 0;
      while (rsp_valid == '0 && cyc < 40) begin
         step();
         cyc++;
      end
      chk("to_latency", 32'(cyc), 16);
      chk("to_rsp_valid", 32'(rsp_valid), 1);
      chk("to_rsp_err", 32'(rsp_err), 1);
      chk("to_rsp_rdata", 32'(rsp_rdata), 0);
      chk("to_m_start", 32'(m_start), 0);
      step();
      chk("to_idle_gnt", 32'(gnt), 0);
`else
      cyc = 0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
